// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity selectors and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Widest data word the parity helper handles; narrower words are zero-extended.
   localparam int MAX_DATA_W = 16;

   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  typ);
      return (^data) ^ (typ == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around the bit centre.
// bit_end strobes in the last cycle of each bit, when sampled_bit is settled.
module uart_rx_sampler #(
   parameter int PRESCALE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic en,
   input  logic rx_in,
   output logic bit_end,
   output logic sampled_bit
);

   localparam int ECW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [ECW-1:0] EDGE_LAST = ECW'(PRESCALE - 1);
   localparam logic [ECW-1:0] EDGE_S0   = ECW'(PRESCALE / 2 - 1);
   localparam logic [ECW-1:0] EDGE_S1   = ECW'(PRESCALE / 2);
   localparam logic [ECW-1:0] EDGE_S2   = ECW'(PRESCALE / 2 + 1);

   logic [ECW-1:0] edge_cnt_q, edge_cnt_d;
   logic [2:0]     smp_q, smp_d;

   always_comb begin
      edge_cnt_d = '0;
      smp_d      = smp_q;
      // The detection cycle is edge 0 of the start bit, so counting resumes at 1.
      if (start) begin
         edge_cnt_d = ECW'(1);
      end else if (en) begin
         edge_cnt_d = (edge_cnt_q == EDGE_LAST) ? '0 : edge_cnt_q + ECW'(1);
         if (edge_cnt_q == EDGE_S0) smp_d[0] = rx_in;
         if (edge_cnt_q == EDGE_S1) smp_d[1] = rx_in;
         if (edge_cnt_q == EDGE_S2) smp_d[2] = rx_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_q <= '0;
         smp_q      <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         smp_q      <= smp_d;
      end
   end

   assign bit_end     = en && (edge_cnt_q == EDGE_LAST);
   assign sampled_bit = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / DATA_WIDTH data bits LSB first / optional parity / stop.
// Good frames update P_DATA with a data_valid pulse; errors pulse par_err/stp_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  party_en,
   input  logic                  party_typ,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

   uart_state_e           state_q, state_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  par_bad_q, par_bad_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic start_det;
   logic bit_end;
   logic sampled_bit;

   assign start_det = (state_q == IDLE) && !RX_IN;

   uart_rx_sampler #(
      .PRESCALE (PRESCALE)
   ) u_sampler (
      .clk         (CLK),
      .rst         (RST),
      .start       (start_det),
      .en          (state_q != IDLE),
      .rx_in       (RX_IN),
      .bit_end     (bit_end),
      .sampled_bit (sampled_bit)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      p_data_d     = p_data_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      par_bad_d    = par_bad_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // Frame options are latched here so mid-frame changes cannot corrupt it.
            if (start_det) begin
               state_d   = START;
               par_en_d  = party_en;
               par_typ_d = party_typ;
               par_bad_d = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               if (sampled_bit) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d[bit_cnt_q] = sampled_bit;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               par_bad_d = sampled_bit != calc_parity(MAX_DATA_W'(shift_q), par_typ_q);
               state_d   = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               if (sampled_bit && !par_bad_q) begin
                  data_valid_d = 1'b1;
                  p_data_d     = shift_q;
               end
               par_err_d = par_bad_q;
               stp_err_d = !sampled_bit;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         p_data_q     <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad_q    <= 1'b0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         p_data_q     <= p_data_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         par_bad_q    <= par_bad_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, pulses logged by a monitor.
module tb_uart_rx;

   localparam int PRE = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX_IN = 1'b1;
   logic       party_en = 1'b0;
   logic       party_typ = 1'b0;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err, busy;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, wide_cnt = 0;
   int dv_cyc = 0, dv_cyc_prev = 0;
   logic [7:0] dv_dat = '0, dv_dat_prev = '0;
   logic dv_q = 1'b0, pe_q = 1'b0, se_q = 1'b0;
   int start_cyc = 0;
   int s;

   uart_rx #(.DATA_WIDTH(8), .PRESCALE(PRE)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .party_en   (party_en),
      .party_typ  (party_typ),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge CLK) begin
      cyc <= cyc + 1;
      if (data_valid) begin
         dv_cnt      <= dv_cnt + 1;
         dv_cyc_prev <= dv_cyc;
         dv_cyc      <= cyc + 1;
         dv_dat_prev <= dv_dat;
         dv_dat      <= P_DATA;
      end
      if (par_err) pe_cnt <= pe_cnt + 1;
      if (stp_err) se_cnt <= se_cnt + 1;
      if ((data_valid && dv_q) || (par_err && pe_q) || (stp_err && se_q))
         wide_cnt <= wide_cnt + 1;
      dv_q <= data_valid;
      pe_q <= par_err;
      se_q <= stp_err;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      RX_IN = b;
      repeat (PRE) @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                             input logic sbit);
      logic [7:0] dd;
      dd = d;
      start_cyc = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(dd[i]);
      if (pe) drive_bit(pbit);
      drive_bit(sbit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_pdata", P_DATA, 8'h00);
      chk("rst_dv", data_valid, 0);
      chk("rst_pe", par_err, 0);
      chk("rst_se", stp_err, 0);
      chk("rst_busy", busy, 0);
      RST = 1'b0;
      idle(4);

      // No parity, 0xEA
      party_en = 1'b0;
      send_frame(8'hEA, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("ea_cnt", dv_cnt, 1);
      chk("ea_dat", dv_dat, 8'hEA);
      chk("ea_lat", dv_cyc - start_cyc, 80);
      chk("ea_pe", pe_cnt, 0);
      chk("ea_se", se_cnt, 0);
      chk("ea_busy", busy, 0);

      // Even parity 0xB3, parity bit 1
      party_en = 1'b1; party_typ = 1'b0;
      send_frame(8'hB3, 1'b1, 1'b1, 1'b1);
      idle(3);
      chk("b3_cnt", dv_cnt, 2);
      chk("b3_dat", dv_dat, 8'hB3);
      chk("b3_lat", dv_cyc - start_cyc, 88);

      // Odd parity 0x17, parity bit 1
      party_typ = 1'b1;
      send_frame(8'h17, 1'b1, 1'b1, 1'b1);
      idle(3);
      chk("17_cnt", dv_cnt, 3);
      chk("17_dat", P_DATA, 8'h17);
      chk("17_pe", pe_cnt, 0);

      // Even parity 0x33 with wrong parity bit
      party_typ = 1'b0;
      send_frame(8'h33, 1'b1, 1'b1, 1'b1);
      idle(3);
      chk("33_pe", pe_cnt, 1);
      chk("33_dv", dv_cnt, 3);
      chk("33_se", se_cnt, 0);
      chk("33_hold", P_DATA, 8'h17);

      // No parity 0x55 with stop bit low, then good 0x0F
      party_en = 1'b0;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("55_se", se_cnt, 1);
      chk("55_dv", dv_cnt, 3);
      chk("55_pe", pe_cnt, 1);
      chk("55_hold", P_DATA, 8'h17);
      send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("0f_cnt", dv_cnt, 4);
      chk("0f_dat", P_DATA, 8'h0F);

      // Start glitch: low for 2 cycles
      RX_IN = 1'b0;
      @(posedge CLK); #1;
      chk("gl_busy1", busy, 1);
      @(posedge CLK); #1;
      RX_IN = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      chk("gl_busy7", busy, 1);
      @(posedge CLK); #1;
      chk("gl_busy8", busy, 0);
      idle(8);
      chk("gl_dv", dv_cnt, 4);
      chk("gl_pe", pe_cnt, 1);
      chk("gl_se", se_cnt, 1);

      // Reset during data bit 4 of 0x3C
      RX_IN = 1'b0;
      repeat (PRE) @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) drive_bit((8'h3C >> i) & 8'h01);
      RX_IN = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("rs_busy", busy, 0);
      chk("rs_pdata", P_DATA, 8'h00);
      chk("rs_dv", data_valid, 0);
      idle(30);
      chk("rs_cnt", dv_cnt + pe_cnt + se_cnt, 6);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("a5_cnt", dv_cnt, 5);
      chk("a5_dat", P_DATA, 8'hA5);

      // Back-to-back 0x01, 0xFE with no idle gap
      send_frame(8'h01, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFE, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("bb_cnt", dv_cnt, 7);
      chk("bb_dat0", dv_dat_prev, 8'h01);
      chk("bb_dat1", dv_dat, 8'hFE);
      chk("bb_gap", dv_cyc - dv_cyc_prev, 80);

      // Break: 200 low cycles -> two stop errors, then a frame reading 0xF0
      RX_IN = 1'b0;
      s = cyc + 1;
      repeat (200) @(posedge CLK);
      #1;
      RX_IN = 1'b1;
      repeat (60) @(posedge CLK);
      #1;
      chk("brk_se", se_cnt, 3);
      chk("brk_dv", dv_cnt, 8);
      chk("brk_dat", dv_dat, 8'hF0);
      chk("brk_lat", dv_cyc - s, 240);
      chk("brk_pe", pe_cnt, 1);

      chk("pulse_width", wide_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, the receive end of the team's UART link.
- Samples RX_IN with a fixed oversampling ratio and frames start / DATA_WIDTH data (LSB first) / optional parity / stop.
- Delivers the byte on P_DATA with a one-cycle data_valid pulse; flags parity and stop errors.
- Frame format and parity convention are identical to the UART transmitter, so TX→RX loopback works directly.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE, 8, CLK cycles per serial bit; even, ≥4.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- RX_IN  in  1  serial line, idle high; already synchronised to CLK upstream.
- party_en  in  1  1 = parity bit present after data.
- party_typ  in  1  0 = even, 1 = odd; ignored when party_en=0.
- P_DATA  out  DATA_WIDTH  last good received word; held until the next good frame.
- data_valid  out  1  one-cycle pulse: P_DATA updated this cycle.
- par_err  out  1  one-cycle pulse: parity mismatch on the frame just ended.
- stp_err  out  1  one-cycle pulse: stop bit sampled low.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE, counters=0, shift register=0, P_DATA=0, data_valid=par_err=stp_err=busy=0.
- RST mid-frame aborts the frame; no output pulse is generated.
- party_en and party_typ are sampled once, at start detection, and held for the frame.
- edge_cnt runs 0..PRESCALE-1 within each bit, then wraps to 0.
- Bit value is the majority of RX_IN at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. It is valid from edge_cnt = PRESCALE/2+2 onward.
- Bit decisions are taken in the bit's last cycle (edge_cnt = PRESCALE-1).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when RX_IN=0, that cycle is edge 0 of the start bit; go to START with edge_cnt=1.
- START end: sampled 1 → glitch, return to IDLE, no pulses. Sampled 0 → DATA with bit_cnt=0.
- DATA: sampled bit is shifted in at position bit_cnt (LSB first). After bit_cnt = DATA_WIDTH-1, go to PARITY if party_en, else STOP.
- PARITY: the expected bit is the XOR of the data bits (even), or its inverse (odd). A mismatch sets an internal error flag; go to STOP.
- STOP: at the end of the bit, return to IDLE. Outputs are registered and visible on the next cycle, which is also the first cycle back in IDLE.
  - No errors: P_DATA ← shift register, data_valid=1.
  - Parity mismatch: par_err=1.
  - Stop bit sampled 0: stp_err=1.
  - Both errors may pulse together. With any error, data_valid stays 0 and P_DATA is unchanged.
- Latency: the pulse appears exactly N·PRESCALE cycles after the start-detection cycle. N = DATA_WIDTH+2, or DATA_WIDTH+3 with parity (80 / 88 cycles at the defaults).
- Back-to-back frames: a falling edge in the first IDLE cycle after STOP is detected normally. The output pulse and the new detection may coincide.
- RX_IN low indefinitely (break): every frame gives stp_err and returns to IDLE; an immediate re-detect is allowed.
- Pulse outputs are never asserted for more than one cycle.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - constants PAR_EVEN=0 and PAR_ODD=1;
  - a parity function shared with the transmitter.
- One sub-module, uart_rx_sampler:
  - edge counter and 3-sample majority vote;
  - outputs: bit_end strobe and sampled_bit;
  - controlled by an enable from the FSM.
- The FSM, bit counter, shift register and output registers live in uart_rx.

Test Plan (PRESCALE=8, DATA_WIDTH=8, each bit held 8 CLKs):
- No parity, 0xEA (line sequence 0,0,1,0,1,0,1,1,1,1) → data_valid pulses 80 cycles after the falling edge; P_DATA=0xEA; par_err=stp_err=0; busy high for 80 cycles.
- Even parity, 0xB3 with parity bit 1 → valid at 88 cycles, P_DATA=0xB3. Odd parity, 0x17 with parity bit 1 → P_DATA=0x17.
- Even parity, 0x33 with parity bit 1 (wrong) → par_err pulse only; P_DATA keeps its previous value; no data_valid.
- No parity, 0x55 with stop bit 0 → stp_err pulse only, no data_valid. A following good 0x0F frame is then received correctly.
- RX_IN low for 2 cycles, then high → start rejected; busy falls after 8 cycles; no pulses of any kind.
- RST asserted for one cycle during data bit 4 → next cycle busy=0 and P_DATA=0, no pulses. A subsequent 0xA5 frame is received; two frames back-to-back (0x01 then 0xFE, no gap) give two data_valid pulses 80 cycles apart.
